serial_pattern_generator: RTL and testbench
===========================================

Name: serial_pattern_generator

Overview:
Serial bit-stream transmitter that drives sequence-detector FSMs such as the three-consecutive-ones alarm detector. It captures a pattern word on a start request and shifts it out MSB-first, one bit per programmable bit period. The whole pattern can be repeated a programmed number of times. It acts as the on-chip stimulus source feeding a detector's in_bit, and reports busy/done status to a controller.

Parameters:
WIDTH, 8, pattern register width in bits
LEN_W, 4, width of length field; must satisfy 2^LEN_W > WIDTH
REP_W, 4, width of repeat-count field
DIV_W, 8, width of bit-period field

Ports:
clk  input  1  clock; all logic on posedge
reset  input  1  synchronous, active-high
start  input  1  request transmission; sampled only in IDLE
abort  input  1  synchronous stop; returns to IDLE
pattern  input  WIDTH  bits to send; bit [length-1] is sent first
length  input  LEN_W  number of pattern bits per repetition
repeat_cnt  input  REP_W  extra repetitions; total passes = repeat_cnt+1
bit_period  input  DIV_W  clocks each bit is held; 0 is treated as 1
out_bit  output  1  serial data; 0 whenever out_valid=0
out_valid  output  1  out_bit carries pattern data (or a guard bit)
busy  output  1  high in SHIFT (and GUARD)
done  output  1  one-cycle pulse at end of a completed transmission
ready  output  1  high in IDLE only

Behaviour:
- States: IDLE, SHIFT, GUARD (only when the optional feature is enabled), DONE.
- reset: state=IDLE; out_bit=0, out_valid=0, busy=0, done=0, internal counters cleared; ready=1. reset has priority over abort and start. Reset mid-stream stops output at the next edge.
- IDLE, start=1 at edge E0: pattern, length, repeat_cnt and bit_period are captured into internal registers.
  - Later input changes have no effect on the transmission in progress.
  - Effective length: length clamped to WIDTH when length > WIDTH.
  - If effective length = 0: go to DONE; out_valid never asserts.
  - Otherwise: go to SHIFT. From the cycle after E0: out_valid=1, busy=1, out_bit=pattern[len-1].
- SHIFT:
  - Each bit is held for max(bit_period,1) cycles, then the next lower bit is presented, down to pattern[0].
  - After the last bit's period, if passes remain: restart at bit [len-1] with no gap (or enter GUARD, see Optional Feature).
  - After the final pass: go to DONE.
- DONE: exactly one cycle with done=1, out_valid=0, out_bit=0, busy=0, ready=0; then IDLE.
- Latency: first bit appears 1 cycle after start is sampled. done asserts in the cycle after the final bit period ends. Total SHIFT cycles = (repeat_cnt+1) * len * max(bit_period,1).
- start while not in IDLE: ignored, not queued. start and abort together in IDLE: abort wins, stay IDLE.
- abort=1 in SHIFT, GUARD or DONE: next state IDLE; outputs go to 0 and done does not pulse.
- Outputs out_bit, out_valid, busy and done are registered. ready is decoded from state.

Optional Feature:
Macro PATTERN_GUARD_EN.
- Defined: between consecutive passes (never after the final pass), the GUARD state sends one guard bit: out_bit=0, out_valid=1, busy=1, held max(bit_period,1) cycles. This forces a downstream detector back to its initial state between repetitions. Total active cycles increase by repeat_cnt * max(bit_period,1).
- Undefined: GUARD state and its logic are not present; passes are concatenated back-to-back.

Test Plan:
1. Reset sequence: reset=1 for 2 cycles, then released -> out_bit=0, out_valid=0, busy=0, done=0, ready=1; state IDLE.
2. Basic transmission: pattern=8'h07, length=3, repeat_cnt=0, bit_period=1, start pulse -> out_bit=1,1,1 with out_valid=1 on the 3 cycles after start; done=1 on the 4th cycle; ready=1 on the 5th. A connected three-ones detector alarms.
3. Bit period: pattern=8'h05, length=3, bit_period=3 -> out_bit 1 for 3 cycles, 0 for 3, 1 for 3; done on cycle 10. bit_period=0 behaves identically to bit_period=1.
4. Repeats: pattern=8'h02, length=2, repeat_cnt=2, bit_period=1 -> 1,0,1,0,1,0 with PATTERN_GUARD_EN undefined. With PATTERN_GUARD_EN defined -> 1,0,0,1,0,0,1,0; done follows the last bit.
5. Length boundaries: length=0 -> done the cycle after start, out_valid stays 0. length=12 with WIDTH=8 and pattern=8'hA5 -> 8 bits 1,0,1,0,0,1,0,1.
6. Abort, reset and ignored start: abort asserted on the 2nd bit of a 3-bit send -> IDLE next cycle, out_valid=0, no done pulse. start re-pulsed while busy -> ignored, original stream unchanged. reset mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/serial_pattern_generator.sv
// serial_pattern_generator: captures a pattern word on start and shifts it out
// MSB-first (bit [length-1] first), each bit held for a programmable number of
// clocks, with the whole pattern repeated repeat_cnt+1 times.
// Optional build macro PATTERN_GUARD_EN inserts a single guard bit (0, valid)
// between consecutive passes.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; ready=1
// ST_SHIFT | presenting pattern bits, one per bit period
// ST_GUARD | guard bit between passes (PATTERN_GUARD_EN builds only)
// ST_DONE  | single-cycle done pulse, then back to ST_IDLE
module serial_pattern_generator #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 4,
   parameter int REP_W = 4,
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] pattern,
   input  logic [LEN_W-1:0] length,
   input  logic [REP_W-1:0] repeat_cnt,
   input  logic [DIV_W-1:0] bit_period,
   output logic             out_bit,
   output logic             out_valid,
   output logic             busy,
   output logic             done,
   output logic             ready
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
`ifdef PATTERN_GUARD_EN
      , ST_GUARD = 2'd3
`endif
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pat_q, pat_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] idx_q, idx_d;
   logic [REP_W-1:0] rep_q, rep_d;
   logic [DIV_W-1:0] per_q, per_d;
   logic [DIV_W-1:0] tmr_q, tmr_d;
   logic             out_bit_q, out_bit_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [LEN_W-1:0] len_eff;
   logic [DIV_W-1:0] per_m1;

   // Select bit i of a pattern word; a shift keeps the index width free.
   function automatic logic bit_at(input logic [WIDTH-1:0] v, input logic [LEN_W-1:0] i);
      logic [WIDTH-1:0] s;
      s = v >> i;
      return s[0];
   endfunction

   // Clamp the requested length to WIDTH; period 0 acts as 1 (reload value = period-1).
   always_comb begin
      len_eff = (length > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : length;
      per_m1  = (bit_period == '0) ? '0 : bit_period - DIV_W'(1);
   end

   // State register, captured configuration, bit timer and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         pat_q       <= '0;
         len_q       <= '0;
         idx_q       <= '0;
         rep_q       <= '0;
         per_q       <= '0;
         tmr_q       <= '0;
         out_bit_q   <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pat_q       <= pat_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         rep_q       <= rep_d;
         per_q       <= per_d;
         tmr_q       <= tmr_d;
         out_bit_q   <= out_bit_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Next-state and next-output decode; outputs default to idle zeros.
   always_comb begin
      state_d     = state_q;
      pat_d       = pat_q;
      len_d       = len_q;
      idx_d       = idx_q;
      rep_d       = rep_q;
      per_d       = per_q;
      tmr_d       = tmr_q;
      out_bit_d   = 1'b0;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               pat_d = pattern;
               len_d = len_eff;
               rep_d = repeat_cnt;
               per_d = per_m1;
               tmr_d = per_m1;
               idx_d = len_eff - LEN_W'(1);
               if (len_eff == '0) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d     = ST_SHIFT;
                  out_bit_d   = bit_at(pattern, len_eff - LEN_W'(1));
                  out_valid_d = 1'b1;
                  busy_d      = 1'b1;
               end
            end
         end

         ST_SHIFT: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else begin
               out_bit_d   = out_bit_q;
               out_valid_d = 1'b1;
               busy_d      = 1'b1;
               if (tmr_q != '0) begin
                  tmr_d = tmr_q - DIV_W'(1);
               end else begin
                  tmr_d = per_q;
                  if (idx_q != '0) begin
                     idx_d     = idx_q - LEN_W'(1);
                     out_bit_d = bit_at(pat_q, idx_q - LEN_W'(1));
                  end else if (rep_q != '0) begin
                     rep_d = rep_q - REP_W'(1);
`ifdef PATTERN_GUARD_EN
                     state_d   = ST_GUARD;
                     out_bit_d = 1'b0;
`else
                     idx_d     = len_q - LEN_W'(1);
                     out_bit_d = bit_at(pat_q, len_q - LEN_W'(1));
`endif
                  end else begin
                     state_d     = ST_DONE;
                     out_bit_d   = 1'b0;
                     out_valid_d = 1'b0;
                     busy_d      = 1'b0;
                     done_d      = 1'b1;
                  end
               end
            end
         end

`ifdef PATTERN_GUARD_EN
         ST_GUARD: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else begin
               out_valid_d = 1'b1;
               busy_d      = 1'b1;
               if (tmr_q != '0) begin
                  tmr_d = tmr_q - DIV_W'(1);
               end else begin
                  tmr_d     = per_q;
                  idx_d     = len_q - LEN_W'(1);
                  out_bit_d = bit_at(pat_q, len_q - LEN_W'(1));
                  state_d   = ST_SHIFT;
               end
            end
         end
`endif

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign out_bit   = out_bit_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign ready     = (state_q == ST_IDLE);

endmodule

// File: tb/tb_serial_pattern_generator.sv
// Directed bench for serial_pattern_generator. A reference model pushes the
// expected per-cycle {out_bit,out_valid,busy,done,ready} into a queue when a
// transmission is launched; each cycle pops one entry and compares it.
module tb_serial_pattern_generator;

   localparam int WIDTH = 8;
   localparam int LEN_W = 4;
   localparam int REP_W = 4;
   localparam int DIV_W = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic             abort;
   logic [WIDTH-1:0] pattern;
   logic [LEN_W-1:0] length;
   logic [REP_W-1:0] repeat_cnt;
   logic [DIV_W-1:0] bit_period;
   logic             out_bit;
   logic             out_valid;
   logic             busy;
   logic             done;
   logic             ready;

   int errors = 0;
   int checks = 0;

   logic [4:0] exp_q[$];

   localparam logic [4:0] E_IDLE  = 5'b00001;
   localparam logic [4:0] E_DONE  = 5'b00010;
   localparam logic [4:0] E_GUARD = 5'b01100;

   serial_pattern_generator #(
      .WIDTH(WIDTH), .LEN_W(LEN_W), .REP_W(REP_W), .DIV_W(DIV_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .abort     (abort),
      .pattern   (pattern),
      .length    (length),
      .repeat_cnt(repeat_cnt),
      .bit_period(bit_period),
      .out_bit   (out_bit),
      .out_valid (out_valid),
      .busy      (busy),
      .done      (done),
      .ready     (ready)
   );

   always #5 clk = ~clk;

   task automatic check_now(input string tag, input logic [4:0] exp);
      logic [4:0] got;
      got = {out_bit, out_valid, busy, done, ready};
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed {bit,valid,busy,done,ready}=%b expected=%b", tag, got, exp);
      end
   endtask

   task automatic check_pop(input string tag);
      logic [4:0] exp;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : E_IDLE;
      check_now(tag, exp);
   endtask

   task automatic drain_n(input string tag, input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         check_pop(tag);
      end
   endtask

   task automatic drain_all(input string tag);
      int n;
      n = exp_q.size();
      drain_n(tag, n);
   endtask

   // Reference model of one complete transmission, starting the cycle after start.
   task automatic push_send(input logic [WIDTH-1:0] pat, input int len, input int rep, input int per);
      int le;
      int pe;
      le = (len > WIDTH) ? WIDTH : len;
      pe = (per == 0) ? 1 : per;
      for (int p = 0; p <= rep; p++) begin
`ifdef PATTERN_GUARD_EN
         if (p > 0 && le > 0)
            for (int k = 0; k < pe; k++) exp_q.push_back(E_GUARD);
`endif
         for (int i = le - 1; i >= 0; i--)
            for (int k = 0; k < pe; k++) exp_q.push_back({pat[i], 4'b1100});
      end
      exp_q.push_back(E_DONE);
      exp_q.push_back(E_IDLE);
   endtask

   // Launch a transmission from IDLE, scramble the inputs after capture, check first cycle.
   task automatic go(input string tag, input logic [WIDTH-1:0] pat, input int len,
                     input int rep, input int per);
      pattern    = pat;
      length     = LEN_W'(len);
      repeat_cnt = REP_W'(rep);
      bit_period = DIV_W'(per);
      start      = 1'b1;
      push_send(pat, len, rep, per);
      @(posedge clk);
      #1;
      start      = 1'b0;
      pattern    = WIDTH'($urandom);
      length     = LEN_W'($urandom);
      repeat_cnt = REP_W'($urandom);
      bit_period = DIV_W'($urandom);
      check_pop(tag);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0;
      pattern = '0; length = '0; repeat_cnt = '0; bit_period = '0;

      // Reset sequence
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check_now("reset", E_IDLE);
      drain_n("reset_idle", 1);

      // Basic 3-ones transmission
      go("basic", 8'h07, 3, 0, 1);
      drain_all("basic");

      // Bit period 3, then period 0 behaves as 1
      go("period3", 8'h05, 3, 0, 3);
      drain_all("period3");
      go("period0", 8'h07, 3, 0, 0);
      drain_all("period0");

      // Repeats (guard bits included when the feature is built in)
      go("repeat", 8'h02, 2, 2, 1);
      drain_all("repeat");
      go("repeat_p2", 8'h02, 2, 1, 2);
      drain_all("repeat_p2");

      // Length boundaries
      go("len0", 8'hFF, 0, 3, 1);
      drain_all("len0");
      go("len12", 8'hA5, 12, 0, 1);
      drain_all("len12");
      go("len8", 8'h3C, 8, 0, 1);
      drain_all("len8");
      go("len1", 8'h01, 1, 1, 2);
      drain_all("len1");

      // start and abort together in IDLE: stay IDLE
      pattern = 8'hFF; length = 4'd3; repeat_cnt = '0; bit_period = 8'd1;
      start = 1'b1; abort = 1'b1;
      exp_q.push_back(E_IDLE);
      exp_q.push_back(E_IDLE);
      drain_all("start_abort_idle");
      start = 1'b0; abort = 1'b0;

      // Abort on the 2nd bit of a 3-bit send: IDLE next cycle, no done
      go("abort", 8'h05, 3, 0, 1);
      exp_q.delete();
      exp_q.push_back(5'b01100);
      drain_all("abort_bit2");
      abort = 1'b1;
      exp_q.push_back(E_IDLE);
      drain_all("abort_idle");
      abort = 1'b0;
      exp_q.push_back(E_IDLE);
      exp_q.push_back(E_IDLE);
      drain_all("abort_nodone");

      // start re-pulsed while busy: ignored, stream unchanged
      go("restart", 8'h05, 3, 0, 2);
      drain_n("restart", 1);
      pattern = 8'h00; length = 4'd8; bit_period = 8'd1; start = 1'b1;
      drain_n("restart_busy", 2);
      start = 1'b0;
      drain_all("restart");

      // Reset mid-stream: outputs zero next cycle
      go("midreset", 8'hFF, 8, 2, 3);
      drain_n("midreset", 2);
      exp_q.delete();
      reset = 1'b1;
      exp_q.push_back(E_IDLE);
      drain_all("midreset_rst");
      reset = 1'b0;
      exp_q.push_back(E_IDLE);
      drain_all("midreset_after");

      // Normal operation resumes after reset
      go("post_reset", 8'h06, 3, 1, 1);
      drain_all("post_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
